// File: rtl/serial_cascade_comparator_pkg.sv
// Shared definitions for the serial cascade comparator: FSM encoding, slice width
// and the sizing rule for the slice counter.
package serial_cascade_comparator_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // The counter holds slice indices 0..WIDTH/2-1 and is never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width / SLICE_W > 1) ? $clog2(width / SLICE_W) : 1;
  endfunction

endpackage

// File: rtl/serial_cascade_comparator_comparator.sv
// Combinational 2-bit magnitude comparator slice with an MSB-side cascade input.
// A lower slice can only refine the result while every higher slice compared equal.
module comparator (
  input  logic EQ1,
  input  logic GT1,
  input  logic A0,
  input  logic A1,
  input  logic B0,
  input  logic B1,
  output logic EQ,
  output logic GT
);

  logic [1:0] a_v;
  logic [1:0] b_v;

  assign a_v = {A1, A0};
  assign b_v = {B1, B0};

  assign EQ = EQ1 & (a_v == b_v);
  assign GT = GT1 | (EQ1 & (a_v > b_v));

endmodule

// File: rtl/serial_cascade_comparator.sv
// Sequential magnitude comparator: feeds operand slices MSB first through a single
// 2-bit comparator slice, one slice per clock, behind a start/done handshake.
module serial_cascade_comparator
  import serial_cascade_comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt
);

  localparam int CNT_W = cnt_width(WIDTH);

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
    $error("serial_cascade_comparator: WIDTH must be even and >= 2");
  end

  state_e           state_q;
  logic [WIDTH-1:0] sa_q, sb_q;
  logic [WIDTH-1:0] sa_d, sb_d;
  logic             ceq_q, cgt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, eq_q, gt_q;
  logic             slice_eq, slice_gt;

  comparator u_slice (
    .EQ1 (ceq_q),
    .GT1 (cgt_q),
    .A0  (sa_q[WIDTH-2]),
    .A1  (sa_q[WIDTH-1]),
    .B0  (sb_q[WIDTH-2]),
    .B1  (sb_q[WIDTH-1]),
    .EQ  (slice_eq),
    .GT  (slice_gt)
  );

  assign sa_d = sa_q << SLICE_W;
  assign sb_d = sb_q << SLICE_W;

  // The final slice result is loaded into eq/gt on the RUN->DONE edge, so the
  // outputs equal ceq/cgt during the done cycle and hold afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ceq_q   <= 1'b0;
      cgt_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            ceq_q   <= 1'b1;
            cgt_q   <= 1'b0;
            cnt_q   <= CNT_W'(WIDTH / SLICE_W - 1);
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          ceq_q <= slice_eq;
          cgt_q <= slice_gt;
          sa_q  <= sa_d;
          sb_q  <= sb_d;
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            eq_q    <= slice_eq;
            gt_q    <= slice_gt;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;

endmodule

// File: tb/tb_serial_cascade_comparator.sv
// Randomized self-checking bench for serial_cascade_comparator at WIDTH=8 and
// exhaustive at WIDTH=2, against a plain integer-compare reference.
module tb_serial_cascade_comparator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, eq8, gt8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, eq2, gt2;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  serial_cascade_comparator #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .eq(eq8), .gt(gt8)
  );

  serial_cascade_comparator #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .eq(eq2), .gt(gt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One WIDTH=8 compare. With hold_start, start stays high and a/b keep changing
  // through the whole compare; the result must still reflect the captured pair.
  task automatic cmp8(input logic [7:0] ta, input logic [7:0] tb_v, input bit hold_start,
                      input string tag);
    int  n;
    int  dones;
    bit  seen;
    bit  busy_drop;
    @(negedge clk);
    a8 = ta; b8 = tb_v; start8 = 1'b1;
    @(posedge clk);
    n = 0; seen = 0; dones = 0; busy_drop = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (!hold_start) start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      if (done8) begin seen = 1; dones++; end
      else begin
        if (!busy8) busy_drop = 1;
        @(posedge clk); n++;
      end
    end
    check({tag, " latency"}, n, 4);
    check({tag, " busy"}, {31'd0, busy_drop}, 0);
    check({tag, " eq"}, {31'd0, eq8}, {31'd0, ta == tb_v});
    check({tag, " gt"}, {31'd0, gt8}, {31'd0, ta > tb_v});
    @(negedge clk);
    start8 = 1'b0;
    check({tag, " idle"}, {29'd0, busy8, done8, eq8}, {29'd0, 1'b0, 1'b0, ta == tb_v});
    if (hold_start) begin
      repeat (8) begin
        @(negedge clk);
        if (done8 || busy8) dones++;
      end
      check({tag, " no_requeue"}, dones, 1);
    end
  endtask

  task automatic cmp2(input logic [1:0] ta, input logic [1:0] tb_v);
    int n;
    bit seen;
    @(negedge clk);
    a2 = ta; b2 = tb_v; start2 = 1'b1;
    @(posedge clk);
    n = 0; seen = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      start2 = 1'b0;
      if (done2) seen = 1;
      else begin @(posedge clk); n++; end
    end
    check($sformatf("w2 %0d,%0d latency", ta, tb_v), n, 1);
    check($sformatf("w2 %0d,%0d result", ta, tb_v), {30'd0, eq2, gt2},
          {30'd0, ta == tb_v, ta > tb_v});
  endtask

  initial begin
    int  dones;
    logic [7:0] ra, rb;

    #1;
    check("reset outputs", {28'd0, busy8, done8, eq8, gt8}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    cmp8(8'hA5, 8'hA5, 0, "equal_a5");
    cmp8(8'h80, 8'h7F, 0, "msb_gt");
    cmp8(8'h3C, 8'h3D, 0, "lsb_lt");
    cmp8(8'h00, 8'hFF, 0, "zero_vs_ff");
    cmp8(8'hFF, 8'hFE, 0, "ff_vs_fe");
    cmp8(8'h5A, 8'h5A, 1, "held_start");

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      if (i % 5 == 4) rb = ra ^ (8'h01 << $urandom_range(0, 7));
      cmp8(ra, rb, 0, $sformatf("rand%0d", i));
    end

    cmp8(8'h42, 8'h42, 0, "pre_reset");
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort outputs", {28'd0, busy8, done8, eq8, gt8}, 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done8 || busy8) dones++;
    end
    check("abort no_done", dones, 0);
    check("abort held", {30'd0, eq8, gt8}, 0);

    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        cmp2(2'(x), 2'(y));

    cmp8(8'h01, 8'h00, 0, "post_abort");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
